// File: rtl/bram_test_pkg.sv
// Shared state/mode types and the expected-data pattern used by the BRAM pattern engine.
package bram_test_pkg;

    localparam int unsigned BTE_MAX_DW = 64;
    localparam int unsigned BTE_MAX_AW = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } bte_state_t;

    typedef enum logic [2:0] {
        ZERO    = 3'd0,
        ONE     = 3'd1,
        CHECKER = 3'd2,
        ADDR    = 3'd3,
        WALK1   = 3'd4
    } bte_mode_t;

    // Pattern word for an address; dw is the live word width, upper bits are masked off.
    function automatic logic [BTE_MAX_DW-1:0] bte_expected(
        input logic [BTE_MAX_AW-1:0] addr,
        input logic [2:0]            mode,
        input logic                  inv,
        input int unsigned           dw
    );
        logic [BTE_MAX_DW-1:0] v;
        logic [BTE_MAX_DW-1:0] mask;
        mask = (dw >= BTE_MAX_DW) ? '1 : ((BTE_MAX_DW'(1) << dw) - BTE_MAX_DW'(1));
        case (mode)
            ONE:     v = '1;
            CHECKER: v = addr[0] ? {8{8'hAA}} : {8{8'h55}};
            ADDR:    v = BTE_MAX_DW'(addr);
            WALK1:   v = BTE_MAX_DW'(1) << (addr % BTE_MAX_AW'(dw));
            default: v = '0;
        endcase
        if (inv) v = ~v;
        return v & mask;
    endfunction

endpackage

// File: rtl/bram_pattern_engine_if.sv
// Control, status and BRAM-port bundle between the pattern engine, its sequencer and the bank.
interface bram_pattern_engine_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned ERR_WIDTH  = 16
);
    logic                  start;
    logic                  abort;
    logic [2:0]            mode;
    logic [7:0]            passes;

    logic                  bram_en;
    logic                  bram_we;
    logic [ADDR_WIDTH-1:0] bram_addr;
    logic [DATA_WIDTH-1:0] bram_din;
    logic [DATA_WIDTH-1:0] bram_dout;

    logic                  busy;
    logic                  done;
    logic                  pass_ok;
    logic [ERR_WIDTH-1:0]  err_count;
    logic [ADDR_WIDTH-1:0] first_err_addr;
    logic                  first_err_valid;

    modport master (
        input  start, abort, mode, passes, bram_dout,
        output bram_en, bram_we, bram_addr, bram_din,
        output busy, done, pass_ok, err_count, first_err_addr, first_err_valid
    );

    modport slave (
        output start, abort, mode, passes, bram_dout,
        input  bram_en, bram_we, bram_addr, bram_din,
        input  busy, done, pass_ok, err_count, first_err_addr, first_err_valid
    );
endinterface

// File: rtl/bram_bank.sv
// Single-port block RAM with a one-cycle registered read.
module bram_bank #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned DEPTH      = 2048
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) r_mem[addr] <= din;
            else    dout        <= r_mem[addr];
        end
    end
endmodule

// File: rtl/bram_pattern_engine.sv
// Write-then-read BRAM traffic generator/checker: selectable pattern, multi-pass with
// odd-pass inversion, saturating error count and first-failure address capture.
module bram_pattern_engine
    import bram_test_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned DEPTH      = 2048,
    parameter int unsigned ERR_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bram_pattern_engine_if.master bus
);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ERR_WIDTH-1:0]  ERR_MAX   = '1;

    bte_state_t            r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
    logic [2:0]            r_mode, w_mode_nxt;
    logic [7:0]            r_passes, w_passes_nxt;
    logic [7:0]            r_pass_idx, w_pass_idx_nxt;
    logic                  r_rd_vld, w_rd_vld_nxt;
    logic [DATA_WIDTH-1:0] r_exp, w_exp_nxt;
    logic [ADDR_WIDTH-1:0] r_cmp_addr, w_cmp_addr_nxt;
    logic                  r_en, w_en_nxt;
    logic                  r_we, w_we_nxt;
    logic [DATA_WIDTH-1:0] r_din, w_din_nxt;
    logic                  r_busy, w_busy_nxt;
    logic                  r_done, w_done_nxt;
    logic                  r_pass_ok, w_pass_ok_nxt;
    logic [ERR_WIDTH-1:0]  r_err_count, w_err_nxt;
    logic [ADDR_WIDTH-1:0] r_ferr_addr, w_ferr_addr_nxt;
    logic                  r_ferr_valid, w_ferr_valid_nxt;
    logic                  w_accept;
    logic                  w_abort;
    logic                  w_mismatch;

    function automatic logic [DATA_WIDTH-1:0] f_pattern(
        input logic [ADDR_WIDTH-1:0] a,
        input logic [2:0]            m,
        input logic                  inv
    );
        return DATA_WIDTH'(bte_expected(BTE_MAX_AW'(a), m, inv, DATA_WIDTH));
    endfunction

    // Next-state, compare and next-output logic; outputs are registered from next-state values.
    always_comb begin
        w_state_nxt    = r_state;
        w_addr_nxt     = r_addr;
        w_mode_nxt     = r_mode;
        w_passes_nxt   = r_passes;
        w_pass_idx_nxt = r_pass_idx;
        w_accept       = 1'b0;
        w_abort        = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    w_accept       = 1'b1;
                    w_state_nxt    = WRITE;
                    w_addr_nxt     = '0;
                    w_mode_nxt     = bus.mode;
                    w_passes_nxt   = (bus.passes == 8'd0) ? 8'd1 : bus.passes;
                    w_pass_idx_nxt = '0;
                end
            end
            WRITE: begin
                if (r_addr == ADDR_LAST) begin
                    w_state_nxt = READ;
                    w_addr_nxt  = '0;
                end else begin
                    w_addr_nxt = r_addr + ADDR_WIDTH'(1);
                end
            end
            READ: begin
                if (r_addr == ADDR_LAST) begin
                    w_state_nxt = DRAIN;
                    w_addr_nxt  = '0;
                end else begin
                    w_addr_nxt = r_addr + ADDR_WIDTH'(1);
                end
            end
            DRAIN: begin
                if ((9'(r_pass_idx) + 9'd1) < 9'(r_passes)) begin
                    w_state_nxt    = WRITE;
                    w_pass_idx_nxt = r_pass_idx + 8'd1;
                end else begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase

        if ((r_state != IDLE) && bus.abort) begin
            w_abort     = 1'b1;
            w_state_nxt = IDLE;
            w_addr_nxt  = '0;
        end

        // Data returned this cycle belongs to the read registered last cycle.
        w_mismatch       = r_rd_vld && !w_abort && (bus.bram_dout != r_exp);
        w_err_nxt        = r_err_count;
        w_ferr_addr_nxt  = r_ferr_addr;
        w_ferr_valid_nxt = r_ferr_valid;
        if (w_accept) begin
            w_err_nxt        = '0;
            w_ferr_valid_nxt = 1'b0;
        end else if (w_mismatch) begin
            if (r_err_count != ERR_MAX) w_err_nxt = r_err_count + ERR_WIDTH'(1);
            if (!r_ferr_valid) begin
                w_ferr_valid_nxt = 1'b1;
                w_ferr_addr_nxt  = r_cmp_addr;
            end
        end

        w_rd_vld_nxt   = (r_state == READ) && !w_abort;
        w_exp_nxt      = f_pattern(r_addr, r_mode, r_pass_idx[0]);
        w_cmp_addr_nxt = r_addr;

        w_en_nxt   = (w_state_nxt == WRITE) || (w_state_nxt == READ);
        w_we_nxt   = (w_state_nxt == WRITE);
        w_din_nxt  = w_we_nxt ? f_pattern(w_addr_nxt, w_mode_nxt, w_pass_idx_nxt[0]) : '0;
        w_busy_nxt = w_en_nxt || (w_state_nxt == DRAIN);
        w_done_nxt = (w_state_nxt == DONE);

        w_pass_ok_nxt = r_pass_ok;
        if (w_accept || w_abort) w_pass_ok_nxt = 1'b0;
        else if (w_done_nxt)     w_pass_ok_nxt = (w_err_nxt == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_mode       <= '0;
            r_passes     <= '0;
            r_pass_idx   <= '0;
            r_rd_vld     <= 1'b0;
            r_exp        <= '0;
            r_cmp_addr   <= '0;
            r_en         <= 1'b0;
            r_we         <= 1'b0;
            r_din        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass_ok    <= 1'b0;
            r_err_count  <= '0;
            r_ferr_addr  <= '0;
            r_ferr_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_addr       <= w_addr_nxt;
            r_mode       <= w_mode_nxt;
            r_passes     <= w_passes_nxt;
            r_pass_idx   <= w_pass_idx_nxt;
            r_rd_vld     <= w_rd_vld_nxt;
            r_exp        <= w_exp_nxt;
            r_cmp_addr   <= w_cmp_addr_nxt;
            r_en         <= w_en_nxt;
            r_we         <= w_we_nxt;
            r_din        <= w_din_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_pass_ok    <= w_pass_ok_nxt;
            r_err_count  <= w_err_nxt;
            r_ferr_addr  <= w_ferr_addr_nxt;
            r_ferr_valid <= w_ferr_valid_nxt;
        end
    end

    // r_addr is parked at zero whenever the port is disabled.
    assign bus.bram_en         = r_en;
    assign bus.bram_we         = r_we;
    assign bus.bram_addr       = r_addr;
    assign bus.bram_din        = r_din;
    assign bus.busy            = r_busy;
    assign bus.done            = r_done;
    assign bus.pass_ok         = r_pass_ok;
    assign bus.err_count       = r_err_count;
    assign bus.first_err_addr  = r_ferr_addr;
    assign bus.first_err_valid = r_ferr_valid;

endmodule

// File: tb/tb_bram_pattern_engine.sv
// Bench for bram_pattern_engine driving a bram_bank, with read-data fault injection.
module tb_bram_pattern_engine;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int D  = 16;
    localparam int EW = 4;
    localparam int L  = 2 * D + 1;
    localparam int ERR_SAT = 15;

    logic clk;
    logic rst_n;
    logic [DW-1:0] w_bank_dout;
    logic          trk_vld;
    logic [AW-1:0] trk_addr;
    int fault_kind;
    int fault_addr;
    int cyc;
    int n_cmp;
    int n_bad;

    // Reference model state
    bit m_active;
    int m_c, m_mode, m_P, m_err, m_fa;
    bit m_fv, m_pok;

    bram_pattern_engine_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ERR_WIDTH(EW)) bus();

    bram_pattern_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(D), .ERR_WIDTH(EW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    bram_bank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(D)) u_bank (
        .clk(clk), .en(bus.bram_en), .we(bus.bram_we), .addr(bus.bram_addr),
        .din(bus.bram_din), .dout(w_bank_dout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        trk_vld  <= bus.bram_en && !bus.bram_we;
        trk_addr <= bus.bram_addr;
    end

    // Memory-side fault injection on returned read data.
    always_comb begin
        bus.bram_dout = w_bank_dout;
        if (trk_vld) begin
            case (fault_kind)
                1: bus.bram_dout = 8'h00;
                2: if (trk_addr == 4'd9) bus.bram_dout = 8'h00;
                3: if (int'(trk_addr) == fault_addr) bus.bram_dout = w_bank_dout ^ 8'h01;
                default: ;
            endcase
        end
    end

    function automatic logic [7:0] m_exp(input int mode, input int a, input int p);
        logic [7:0] v;
        case (mode)
            1: v = 8'hFF;
            2: v = (a % 2 == 1) ? 8'hAA : 8'h55;
            3: v = 8'(a);
            4: v = 8'(1 << (a % 8));
            default: v = 8'h00;
        endcase
        if (p % 2 == 1) v = ~v;
        return v;
    endfunction

    function automatic logic [7:0] m_dout(input int a, input logic [7:0] e);
        case (fault_kind)
            1: return 8'h00;
            2: return (a == 9) ? 8'h00 : e;
            3: return (a == fault_addr) ? (e ^ 8'h01) : e;
            default: return e;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    // Per-cycle compare against the model, then advance the model using this cycle's inputs.
    always @(negedge clk) begin
        int r, p, a, q;
        logic [7:0] e, e_din;
        logic [3:0] e_addr;
        logic e_en, e_we, e_busy, e_done;
        e_en = 0; e_we = 0; e_addr = 0; e_din = 0; e_busy = 0; e_done = 0;
        if (!rst_n) begin
            m_active = 0; m_err = 0; m_fv = 0; m_fa = 0; m_pok = 0;
        end else if (m_active) begin
            if (m_c <= m_P * L) begin
                r = (m_c - 1) % L;
                p = (m_c - 1) / L;
                e_busy = 1;
                if (r < D) begin
                    e_en = 1; e_we = 1; e_addr = 4'(r); e_din = m_exp(m_mode, r, p);
                end else if (r < 2 * D) begin
                    e_en = 1; e_addr = 4'(r - D);
                end
            end else begin
                e_done = 1;
            end
        end
        check("bram_en", bus.bram_en, e_en);
        check("bram_we", bus.bram_we, e_we);
        check("bram_addr", bus.bram_addr, e_addr);
        check("bram_din", bus.bram_din, e_din);
        check("busy", bus.busy, e_busy);
        check("done", bus.done, e_done);
        check("pass_ok", bus.pass_ok, m_pok);
        check("err_count", bus.err_count, 64'(m_err));
        check("first_err_valid", bus.first_err_valid, m_fv);
        check("first_err_addr", bus.first_err_addr, 64'(m_fa));
        if (rst_n) begin
            if (m_active) begin
                if (bus.abort) begin
                    m_active = 0;
                    m_pok = 0;
                end else begin
                    if (m_c >= 2) begin
                        r = (m_c - 2) % L;
                        if (r >= D && r < 2 * D) begin
                            a = r - D;
                            q = (m_c - 2) / L;
                            e = m_exp(m_mode, a, q);
                            if (m_dout(a, e) != e) begin
                                if (m_err != ERR_SAT) m_err++;
                                if (!m_fv) begin m_fv = 1; m_fa = a; end
                            end
                        end
                    end
                    if (m_c == m_P * L) m_pok = (m_err == 0);
                    if (m_c == m_P * L + 1) m_active = 0;
                    else m_c++;
                end
            end else if (bus.start && !bus.abort) begin
                m_active = 1; m_c = 1; m_mode = int'(bus.mode);
                m_P = (bus.passes == 0) ? 1 : int'(bus.passes);
                m_err = 0; m_fv = 0; m_pok = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input int md, input int ps);
        bus.mode = 3'(md); bus.passes = 8'(ps); bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(inout int c);
        while (bus.done !== 1'b1 && c < 1000) begin
            tick();
            c++;
        end
        if (c >= 1000) begin
            n_cmp++; n_bad++;
            $display("FAIL done_timeout @cyc %0d: no done within 1000 cycles", cyc);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        n_cmp = 0; n_bad = 0; cyc = 0; fault_kind = 0; fault_addr = 0;
        trk_vld = 0; trk_addr = 0;
        bus.start = 0; bus.abort = 0; bus.mode = 0; bus.passes = 0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // Checkerboard, one pass
        launch(2, 1); c = 1; wait_done(c);
        check("t1_done_cycle", 64'(c), 34);
        check("t1_pass_ok", bus.pass_ok, 1);
        check("t1_err", bus.err_count, 0);
        repeat (2) tick();

        // Address pattern, two passes; pass 1 addr 5 is inverted
        launch(3, 2); c = 1;
        repeat (38) begin tick(); c++; end
        check("t2_din_inv_addr5", bus.bram_din, 8'hFA);
        check("t2_we_inv_addr5", bus.bram_we, 1);
        wait_done(c);
        check("t2_done_cycle", 64'(c), 67);
        check("t2_pass_ok", bus.pass_ok, 1);
        repeat (2) tick();

        // Single corrupted read at address 9
        fault_kind = 2;
        launch(1, 1); c = 1; wait_done(c);
        check("t3_err", bus.err_count, 1);
        check("t3_first_addr", bus.first_err_addr, 9);
        check("t3_first_valid", bus.first_err_valid, 1);
        check("t3_pass_ok", bus.pass_ok, 0);
        tick();

        // Stuck-at-0 read data, counter saturates
        fault_kind = 1;
        launch(1, 2); c = 1; wait_done(c);
        check("t4_err_sat", bus.err_count, 15);
        check("t4_first_addr", bus.first_err_addr, 0);
        check("t4_pass_ok", bus.pass_ok, 0);
        tick();

        // Abort in READ at address 6, then start+abort together in IDLE
        launch(1, 1); c = 1;
        repeat (22) begin tick(); c++; end
        check("t5_read_addr", bus.bram_addr, 6);
        check("t5_read_we", bus.bram_we, 0);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("t5_abort_en", bus.bram_en, 0);
        check("t5_abort_busy", bus.busy, 0);
        check("t5_abort_done", bus.done, 0);
        check("t5_abort_err_hold", bus.err_count, 5);
        bus.start = 1'b1; bus.abort = 1'b1;
        tick();
        bus.start = 1'b0; bus.abort = 1'b0;
        tick();
        check("t5_nostart_busy", bus.busy, 0);
        check("t5_nostart_en", bus.bram_en, 0);
        check("t5_nostart_err", bus.err_count, 5);
        fault_kind = 0;

        // Reset mid-WRITE, then passes=0 runs a single pass
        launch(0, 3);
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        check("t6_rst_en", bus.bram_en, 0);
        check("t6_rst_busy", bus.busy, 0);
        check("t6_rst_din", bus.bram_din, 0);
        check("t6_rst_err", bus.err_count, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        launch(4, 0); c = 1; wait_done(c);
        check("t6_done_cycle", 64'(c), 34);
        check("t6_pass_ok", bus.pass_ok, 1);
        tick();

        // Randomized runs checked by the per-cycle model
        repeat (30) begin
            int md, ps, pp, ab;
            fault_kind = int'($urandom_range(0, 3));
            fault_addr = int'($urandom_range(0, 15));
            md = int'($urandom_range(0, 7));
            ps = int'($urandom_range(0, 3));
            pp = (ps == 0) ? 1 : ps;
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, pp * L + 1)) : 0;
            if ($urandom_range(0, 4) == 0) begin
                bus.start = 1'b1; bus.abort = 1'b1;
                tick();
                bus.start = 1'b0; bus.abort = 1'b0;
            end
            launch(md, ps);
            c = 1;
            while (m_active && c < 1000) begin
                bus.abort = (c == ab);
                bus.start = (c < pp * L) ? 1'($urandom_range(0, 1)) : 1'b0;
                tick();
                c++;
            end
            bus.abort = 1'b0; bus.start = 1'b0;
            if (c >= 1000) begin
                n_cmp++; n_bad++;
                $display("FAIL rand_run_timeout @cyc %0d: run did not finish", cyc);
            end
            repeat ($urandom_range(1, 3)) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
